// File: rtl/decomp_dispatch.sv
// -----------------------------------------------------------------------------
// decomp_dispatch
// Splits a stream of fixed-size compressed frames (BEATS beats each) onto one
// of three decompression engines, chosen by the codec sampled with the first
// beat. Only the first len payload beats are forwarded; the remaining padding
// beats are consumed. Framing errors produce a one-cycle err_o pulse, and the
// offending frame is dropped, cut short or restarted as appropriate.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   data_i              compressed beat
//   valid_i / ready_o   input handshake (beat accepted on valid_i & ready_o)
//   sop_i / eop_i       first / BEATS-th beat of an input frame
//   mode_i              codec with sop_i: 01 SR, 10 ZRL, 11 BPC, 00 illegal
//   len_i               payload beats with sop_i, legal 1..BEATS
//   data_o              routed payload beat
//   valid_o / ready_i   one-hot engine select: bit0 BPC, bit1 ZRL, bit2 SR
//   sop_o / eop_o       first / last payload beat
//   err_o               one-cycle framing-error pulse
//   err_cnt_o           saturating error count (only with DECOMP_ERR_CNT_EN)
//
// Build option: define DECOMP_ERR_CNT_EN to add the err_cnt_o counter port.
// -----------------------------------------------------------------------------
module decomp_dispatch #(
    parameter int BEATS      = 8,
    parameter int D_BITWIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [D_BITWIDTH-1:0] data_i,
    input  logic                  valid_i,
    input  logic                  sop_i,
    input  logic                  eop_i,
    input  logic [1:0]            mode_i,
    input  logic [3:0]            len_i,
    output logic                  ready_o,
    output logic [D_BITWIDTH-1:0] data_o,
    output logic [2:0]            valid_o,
    input  logic [2:0]            ready_i,
    output logic                  sop_o,
    output logic                  eop_o,
`ifdef DECOMP_ERR_CNT_EN
    output logic [15:0]           err_cnt_o,
`endif
    output logic                  err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        PAD  = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam logic [3:0] BEATS4 = 4'(BEATS);
    localparam logic [4:0] BEATS5 = 5'(BEATS);

    // registered state
    state_t                r_state;
    logic [3:0]            r_bcnt;
    logic [1:0]            r_mode;
    logic [3:0]            r_len;
    logic [2:0]            r_osel;   // nonzero means the output register is full
    logic [D_BITWIDTH-1:0] r_data;
    logic                  r_sop;
    logic                  r_eop;
    logic                  r_err;
`ifdef DECOMP_ERR_CNT_EN
    logic [15:0]           r_err_cnt;
`endif

    // decode
    logic       w_take;
    logic       w_busy;
    logic       w_acc;
    logic       w_legal;
    logic       w_start;
    logic [3:0] w_n;
    logic       w_last;
    logic       w_done;
    state_t     w_nstate;
    logic [3:0] w_nbcnt;
    logic       w_fwd;
    logic       w_fsop;
    logic       w_feop;
    logic       w_err;
    logic       w_latch;
    logic [2:0] w_fsel;

    function automatic logic [2:0] sel_of(input logic [1:0] m);
        case (m)
            2'b01:   sel_of = 3'b100;  // SR
            2'b10:   sel_of = 3'b010;  // ZRL
            2'b11:   sel_of = 3'b001;  // BPC
            default: sel_of = 3'b000;
        endcase
    endfunction

    assign w_take = |(r_osel & ready_i);
    assign w_busy = (r_osel != 3'b000) && !w_take;

    // PAD/DROP normally swallow beats unconditionally. A restart sop arriving
    // in PAD has to be forwarded, so it is held off while the output register
    // cannot take it; otherwise that beat would be lost.
    always_comb begin
        ready_o = !w_busy;
        if (r_state == DROP)
            ready_o = 1'b1;
        else if (r_state == PAD)
            ready_o = !(valid_i && sop_i && w_busy);
    end

    assign w_acc   = valid_i & ready_o;
    assign w_legal = (mode_i != 2'b00) && (len_i != 4'd0) && ({1'b0, len_i} <= BEATS5);
    assign w_start = w_acc && sop_i && (r_state != DROP);
    assign w_n     = r_bcnt + 4'd1;
    assign w_last  = (w_n == BEATS4);
    assign w_done  = w_last | eop_i;

    always_comb begin
        w_nstate = r_state;
        w_nbcnt  = r_bcnt;
        w_fwd    = 1'b0;
        w_fsop   = 1'b0;
        w_feop   = 1'b0;
        w_err    = 1'b0;
        w_latch  = 1'b0;
        w_fsel   = sel_of(r_mode);
        if (w_start) begin
            // The start beat is beat 1 of the new frame, so w_last is not
            // meaningful here; beat 1 closes the frame only when BEATS == 1.
            w_err = (r_state != IDLE) | !w_legal |
                    (eop_i ^ (BEATS4 == 4'd1));
            if (w_legal) begin
                w_latch = 1'b1;
                w_fwd   = 1'b1;
                w_fsop  = 1'b1;
                w_feop  = (len_i == 4'd1);
                w_fsel  = sel_of(mode_i);
                if (eop_i || BEATS4 == 4'd1)
                    w_nstate = IDLE;
                else if (len_i == 4'd1)
                    w_nstate = PAD;
                else
                    w_nstate = PASS;
            end else begin
                w_nstate = (eop_i || BEATS4 == 4'd1) ? IDLE : DROP;
            end
            w_nbcnt = (w_nstate == IDLE) ? 4'd0 : 4'd1;
        end else if (w_acc) begin
            case (r_state)
                IDLE: w_err = 1'b1;
                PASS: begin
                    w_fwd    = 1'b1;
                    w_feop   = (w_n == r_len);
                    w_err    = eop_i ^ w_last;
                    w_nstate = w_done ? IDLE : ((w_n == r_len) ? PAD : PASS);
                    w_nbcnt  = w_done ? 4'd0 : w_n;
                end
                PAD: begin
                    w_err    = eop_i ^ w_last;
                    w_nstate = w_done ? IDLE : PAD;
                    w_nbcnt  = w_done ? 4'd0 : w_n;
                end
                default: begin  // DROP: the frame already reported its error
                    w_nstate = w_done ? IDLE : DROP;
                    w_nbcnt  = w_done ? 4'd0 : w_n;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_bcnt  <= 4'd0;
            r_mode  <= 2'b00;
            r_len   <= 4'd0;
            r_osel  <= 3'b000;
            r_data  <= '0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_bcnt  <= w_nbcnt;
            r_err   <= w_err;
            if (w_latch) begin
                r_mode <= mode_i;
                r_len  <= len_i;
            end
            if (w_fwd) begin
                r_osel <= w_fsel;
                r_data <= data_i;
                r_sop  <= w_fsop;
                r_eop  <= w_feop;
            end else if (w_take) begin
                r_osel <= 3'b000;
                r_sop  <= 1'b0;
                r_eop  <= 1'b0;
            end
        end
    end

`ifdef DECOMP_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err_cnt <= 16'd0;
        else if (w_err && r_err_cnt != 16'hFFFF)
            r_err_cnt <= r_err_cnt + 16'd1;
    end
    assign err_cnt_o = r_err_cnt;
`endif

    assign valid_o = r_osel;
    assign data_o  = r_data;
    assign sop_o   = r_sop;
    assign eop_o   = r_eop;
    assign err_o   = r_err;

endmodule

// File: doc/decomp_dispatch.md
DECOMP_DISPATCH -- requirements
Module: decomp_dispatch

Interface
REQ-001 SHALL have parameter BEATS, default 8: beats per compressed frame.
REQ-002 SHALL have parameter D_BITWIDTH, default 64: beat data width.
REQ-003 SHALL have clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have data_i  input  64: compressed beat.
REQ-006 SHALL have valid_i  input  1: beat valid.
REQ-007 SHALL have sop_i  input  1: first beat of frame.
REQ-008 SHALL have eop_i  input  1: last (BEATS-th) beat of frame.
REQ-009 SHALL have mode_i  input  2: frame codec, sampled with sop_i (01 SR, 10 ZRL, 11 BPC, 00 illegal).
REQ-010 SHALL have len_i  input  4: payload beats in frame, sampled with sop_i, legal 1..BEATS; remaining beats are padding.
REQ-011 SHALL have ready_o  output  1: beat accepted when valid_i & ready_o.
REQ-012 SHALL have data_o  output  64: routed payload beat.
REQ-013 SHALL have valid_o  output  3: one-hot engine select; bit0 BPC, bit1 ZRL, bit2 SR.
REQ-014 SHALL have ready_i  input  3: per-engine ready, same bit mapping.
REQ-015 SHALL have sop_o, eop_o  output  1 each: first/last payload beat.
REQ-016 SHALL have err_o  output  1: one-cycle framing-error pulse.

Function
REQ-017 SHALL hold a one-entry output register; transfer occurs when valid_o[k] & ready_i[k]; data/sop/eop stable while valid_o nonzero and not taken.
REQ-018 SHALL drive ready_o = (out register empty) | (out register transferring this cycle), except in PAD/DROP where ready_o = 1.
REQ-019 SHALL have latency of exactly 1 cycle from accepted payload beat to valid_o.
REQ-020 SHALL implement FSM IDLE, PASS, PAD, DROP with a 4-bit beat counter bcnt (beats accepted in current frame).
REQ-021 IDLE: accepted beat with sop_i and legal mode/len -> latch mode/len, forward beat with sop_o=1, bcnt=1, go PASS (or PAD if len=1, or IDLE if BEATS=1).
REQ-022 PASS: each accepted beat forwarded; beat number len gets eop_o=1; then PAD if len<BEATS, else IDLE.
REQ-023 PAD: accepted beats consumed, not forwarded; return IDLE after beat BEATS.
REQ-024 len=1 SHALL give sop_o=1 and eop_o=1 on the same beat.
REQ-025 IDLE beat without sop_i SHALL be discarded and pulse err_o.
REQ-026 sop_i with mode_i=00, len_i=0 or len_i>BEATS SHALL pulse err_o and enter DROP; DROP consumes beats through eop_i or beat BEATS, then IDLE; nothing forwarded.
REQ-027 sop_i before beat BEATS in PASS/PAD SHALL pulse err_o and restart a new frame on that beat; if in PASS, the previous frame's last forwarded beat is not re-marked eop.
REQ-028 eop_i on beat other than BEATS SHALL pulse err_o and return IDLE after that beat; if BEATS is reached without eop_i, err_o pulses, frame closes normally.
REQ-029 Multiple error causes on one beat SHALL yield a single err_o pulse.
REQ-030 valid_o SHALL never have more than one bit set.

Reset
REQ-031 rst_n low SHALL asynchronously force FSM=IDLE, bcnt=0, out register empty, valid_o=000, data_o=0, sop_o=0, eop_o=0, err_o=0, ready_o=1 after release.
REQ-032 Reset mid-frame SHALL discard the partial frame; next accepted beat is treated as IDLE.

Configuration
REQ-033 With DECOMP_ERR_CNT_EN defined, SHALL add output err_cnt_o [15:0], incremented per err_o pulse, saturating at 16'hFFFF, reset to 0.
REQ-034 Without DECOMP_ERR_CNT_EN, err_cnt_o SHALL not exist; all other behaviour identical.

Verification
REQ-035 SR frame mode=01, len=8, 8 beats, ready_i=111 -> 8 beats on valid_o=100, sop_o on beat 1, eop_o on beat 8, err_o never high.
REQ-036 ZRL frame mode=10, len=3 -> 3 beats on valid_o=010, eop_o on beat 3; beats 4..8 consumed, ready_o=1, not forwarded.
REQ-037 BPC frame len=8, ready_i[0] low cycles 3-5 -> data_o held, ready_o low, no beat lost or duplicated.
REQ-038 mode=00 frame -> err_o one pulse, zero output beats, following legal BPC len=2 frame forwarded correctly.
REQ-039 sop_i on beat 5 of PASS frame -> err_o pulse, new frame started with sop_o=1 on that beat.
REQ-040 rst_n asserted at beat 4 of a len=8 frame -> valid_o=000 immediately; next legal frame passes cleanly; with DECOMP_ERR_CNT_EN, 3 errors -> err_cnt_o=3.
